// File: rtl/afe_spi_driver_pkg.sv
// afe_spi_driver_pkg: rate and width helpers shared by the AFE SPI driver files.
package afe_spi_driver_pkg;

    function automatic int half_ticks(input int clk_rate, input int spi_rate);
        return (clk_rate + 2 * spi_rate - 1) / (2 * spi_rate);
    endfunction

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/afe_spi_driver_tick_gen.sv
// spi_tick_gen: reloadable down-counter; done_o is high on the last of N cycles after a load.
module spi_tick_gen #(
    parameter int N = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic done_o
);
    localparam int W = $clog2(N + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? W'(N - 1) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/afe_spi_driver.sv
// afe_spi_driver: shifts one latched word MSB-first onto the selected AFE SPI bus,
// then strobes latch-enable; every state lasts HALF_TICKS sysClk cycles.
module afe_spi_driver
    import afe_spi_driver_pkg::*;
#(
    parameter int CLK_RATE      = 99999001,
    parameter int SPI_RATE      = 5000000,
    parameter int CHANNEL_COUNT = 2,
    parameter int DATA_WIDTH    = 24
) (
    input  logic                                 sysClk,
    input  logic                                 sysReset_n,
    input  logic                                 start,
    input  logic [width_of(CHANNEL_COUNT)-1:0]   channel,
    input  logic [DATA_WIDTH-1:0]                data,
    output logic                                 busy,
    output logic                                 dropped,
    output logic [CHANNEL_COUNT-1:0]             spi_clk,
    output logic [CHANNEL_COUNT-1:0]             spi_sdi,
    output logic [CHANNEL_COUNT-1:0]             spi_le
);
    localparam int HALF_TICKS = half_ticks(CLK_RATE, SPI_RATE);
    localparam int CW         = width_of(CHANNEL_COUNT);
    localparam int BW         = width_of(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, CLK_LO, CLK_HI, GAP, LE, HOLD} state_t;

    if (HALF_TICKS < 1) begin : g_bad_rate
        $error("HALF_TICKS must be at least 1");
    end

    state_t                   state_q;
    logic [DATA_WIDTH-1:0]    sh_q, sh_nx;
    logic [BW-1:0]            bit_q;
    logic [CW-1:0]            ch_q;
    logic                     busy_q, dropped_q;
    logic [CHANNEL_COUNT-1:0] clk_q, sdi_q, le_q;
    logic [CHANNEL_COUNT-1:0] sel, acc_sel;
    logic                     accept, load, done;

    assign accept  = start && state_q == IDLE && int'(channel) < CHANNEL_COUNT;
    assign load    = accept || (state_q != IDLE && state_q != HOLD && done);
    assign sel     = CHANNEL_COUNT'(1) << ch_q;
    assign acc_sel = CHANNEL_COUNT'(1) << channel;
    assign sh_nx   = sh_q << 1;

    spi_tick_gen #(.N(HALF_TICKS)) u_tick (
        .clk_i  (sysClk),
        .rst_ni (sysReset_n),
        .load_i (load),
        .done_o (done)
    );

    // SDI changes on the same edge that drops CLK, so the AFE sees a full half-period of setup and hold
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_q     <= '0;
            ch_q      <= '0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
            clk_q     <= '0;
            sdi_q     <= '0;
            le_q      <= '0;
        end else begin
            dropped_q <= start && !accept;
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= CLK_LO;
                    busy_q  <= 1'b1;
                    ch_q    <= channel;
                    sh_q    <= data;
                    bit_q   <= BW'(DATA_WIDTH - 1);
                    sdi_q   <= data[DATA_WIDTH-1] ? acc_sel : '0;
                end
                CLK_LO: if (done) begin
                    state_q <= CLK_HI;
                    clk_q   <= sel;
                end
                CLK_HI: if (done) begin
                    clk_q <= '0;
                    if (bit_q == '0) begin
                        state_q <= GAP;
                        sdi_q   <= '0;
                    end else begin
                        state_q <= CLK_LO;
                        bit_q   <= bit_q - 1'b1;
                        sh_q    <= sh_nx;
                        sdi_q   <= sh_nx[DATA_WIDTH-1] ? sel : '0;
                    end
                end
                GAP: if (done) begin
                    state_q <= LE;
                    le_q    <= sel;
                end
                LE: if (done) begin
                    state_q <= HOLD;
                    le_q    <= '0;
                end
                HOLD: if (done) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign dropped = dropped_q;
    assign spi_clk = clk_q;
    assign spi_sdi = sdi_q;
    assign spi_le  = le_q;

endmodule

// File: tb/tb_afe_spi_driver.sv
// tb_afe_spi_driver: directed writes checked against a timing model of the SPI frame
// plus hand-computed expectations for captured words, pulse widths and delays.
module tb_afe_spi_driver;
    localparam int H    = 10;
    localparam int DW   = 24;
    localparam int BUSY = H * (2 * DW + 3);

    logic        sysClk = 1'b0, sysReset_n = 1'b0, start = 1'b0;
    logic        channel = 1'b0;
    logic [23:0] data = '0;
    logic        busy, dropped;
    logic [1:0]  spi_clk, spi_sdi, spi_le;
    logic        start3 = 1'b0;
    logic [1:0]  channel3 = '0;
    logic        busy3, dropped3;
    logic [2:0]  clk3, sdi3, le3;

    int checks = 0, errors = 0;

    always #5 sysClk = ~sysClk;

    afe_spi_driver dut (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .start(start), .channel(channel), .data(data),
        .busy(busy), .dropped(dropped), .spi_clk(spi_clk), .spi_sdi(spi_sdi), .spi_le(spi_le)
    );

    afe_spi_driver #(.CHANNEL_COUNT(3)) dut3 (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .start(start3), .channel(channel3), .data(data),
        .busy(busy3), .dropped(dropped3), .spi_clk(clk3), .spi_sdi(sdi3), .spi_le(le3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Model: one frame per accepted start, described by its accept edge, word and channel
    int          cyc = 0, m_a = 0, m_c = 0;
    logic        m_act = 1'b0, m_drop = 1'b0;
    logic [23:0] m_w = '0;

    always @(posedge sysClk) begin
        cyc++;
        m_drop = 1'b0;
        if (!sysReset_n) m_act = 1'b0;
        else if (start) begin
            if ((!m_act || cyc > m_a + BUSY) && int'(channel) < 2) begin
                m_act = 1'b1;
                m_a   = cyc;
                m_w   = data;
                m_c   = int'(channel);
            end else m_drop = 1'b1;
        end
    end

    int         t, ph;
    logic [7:0] e;
    logic [1:0] c1;

    always @(negedge sysClk) begin
        t  = cyc - m_a;
        e  = '0;
        c1 = 2'(1) << m_c;
        if (sysReset_n) begin
            e[6] = m_drop;
            if (m_act && t < BUSY) begin
                ph   = t / H;
                e[7] = 1'b1;
                if (ph < 2 * DW) begin
                    e[5:4] = (ph % 2 == 1) ? c1 : 2'b00;
                    e[3:2] = m_w[DW-1-ph/2] ? c1 : 2'b00;
                end else if (ph == 2 * DW + 1) e[1:0] = c1;
            end
        end
        chk("cycle", {24'b0, busy, dropped, spi_clk, spi_sdi, spi_le}, {24'b0, e});
        chk("dut3_quiet", {22'b0, busy3, clk3, sdi3, le3}, 32'b0);
    end

    logic [23:0] cap [2] = '{24'b0, 24'b0};
    int          rises [2] = '{0, 0};
    int          le_cnt [2] = '{0, 0};
    int          le_at [2] = '{-1, -1};
    int          busy_cnt = 0, ncyc = 0;
    logic [1:0]  pclk = '0, ple = '0;
    logic        clr = 1'b0;

    always @(negedge sysClk) begin
        for (int c = 0; c < 2; c++) begin
            if (clr) begin
                cap[c] = '0; rises[c] = 0; le_cnt[c] = 0; le_at[c] = -1;
            end else begin
                if (spi_clk[c] && !pclk[c]) begin
                    cap[c] = {cap[c][22:0], spi_sdi[c]};
                    rises[c]++;
                end
                if (spi_le[c]) le_cnt[c]++;
                if (spi_le[c] && !ple[c]) le_at[c] = ncyc;
            end
        end
        busy_cnt = clr ? 0 : busy_cnt + int'(busy);
        pclk = spi_clk;
        ple  = spi_le;
        ncyc++;
    end

    task automatic clear();
        clr = 1'b1;
        @(negedge sysClk);
        @(posedge sysClk); #1;
        clr = 1'b0;
    endtask

    task automatic send(input int ch, input logic [23:0] w, output int sc);
        start   = 1'b1;
        channel = 1'(ch);
        data    = w;
        sc      = ncyc;
        @(posedge sysClk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output logic to);
        int n = 0;
        while (busy && n < 700) begin
            @(posedge sysClk); #1;
            n++;
        end
        to = busy;
    endtask

    initial begin
        logic to;
        int   s0, n;
        repeat (3) @(posedge sysClk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dropped", 32'(dropped), 0);
        chk("rst_clk", 32'(spi_clk), 0);
        chk("rst_sdi", 32'(spi_sdi), 0);
        chk("rst_le", 32'(spi_le), 0);
        sysReset_n = 1'b1;
        @(posedge sysClk); #1;

        clear();
        send(0, 24'hA5F00F, s0);
        wait_idle(to);
        chk("basic_timeout", 32'(to), 0);
        chk("basic_word", 32'(cap[0]), 32'hA5F00F);
        chk("basic_busy_len", busy_cnt, 510);
        chk("basic_le_len", le_cnt[0], 10);
        chk("basic_rises", rises[0], 24);
        chk("basic_ch1_clk", rises[1], 0);
        chk("basic_ch1_le", le_cnt[1], 0);

        clear();
        send(1, 24'h000001, s0);
        wait_idle(to);
        chk("ch1_timeout", 32'(to), 0);
        chk("ch1_word", 32'(cap[1]), 32'h000001);
        chk("ch1_le_delay", le_at[1] - s0, 491);
        chk("ch1_le_len", le_cnt[1], 10);
        chk("ch1_ch0_clk", rises[0], 0);

        clear();
        send(0, 24'h3C5A96, s0);
        repeat (99) begin @(posedge sysClk); #1; end
        start = 1'b1; channel = 1'b0; data = 24'hFFFFFF;
        @(posedge sysClk); #1;
        start = 1'b0;
        chk("rej_dropped", 32'(dropped), 1);
        @(posedge sysClk); #1;
        chk("rej_dropped_end", 32'(dropped), 0);
        wait_idle(to);
        repeat (20) begin @(posedge sysClk); #1; end
        chk("rej_timeout", 32'(to), 0);
        chk("rej_word", 32'(cap[0]), 32'h3C5A96);
        chk("rej_busy_len", busy_cnt, 510);
        chk("rej_le_len", le_cnt[0], 10);

        clear();
        send(0, 24'h5A5A5A, s0);
        wait_idle(to);
        chk("b2b_timeout1", 32'(to), 0);
        send(1, 24'hC3F00C, s0);
        chk("b2b_busy", 32'(busy), 1);
        wait_idle(to);
        chk("b2b_timeout2", 32'(to), 0);
        chk("b2b_word0", 32'(cap[0]), 32'h5A5A5A);
        chk("b2b_word1", 32'(cap[1]), 32'hC3F00C);
        chk("b2b_busy_len", busy_cnt, 1020);
        chk("b2b_le0", le_cnt[0], 10);
        chk("b2b_le1", le_cnt[1], 10);

        start3 = 1'b1; channel3 = 2'd3;
        @(posedge sysClk); #1;
        start3 = 1'b0;
        chk("inv_dropped", 32'(dropped3), 1);
        chk("inv_busy", 32'(busy3), 0);
        @(posedge sysClk); #1;
        chk("inv_dropped_end", 32'(dropped3), 0);
        chk("inv_pins", {23'b0, clk3, sdi3, le3}, 0);

        clear();
        send(0, 24'hF0F0F0, s0);
        n = 0;
        while (rises[0] < 12 && n < 400) begin
            @(posedge sysClk); #1;
            n++;
        end
        chk("mid_rises", rises[0], 12);
        sysReset_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {24'b0, busy, dropped, spi_clk, spi_sdi, spi_le}, 0);
        repeat (3) begin @(posedge sysClk); #1; end
        sysReset_n = 1'b1;
        repeat (600) begin @(posedge sysClk); #1; end
        chk("mid_no_le", le_cnt[0], 0);
        chk("mid_idle", 32'(busy), 0);
        clear();
        send(0, 24'h6B1D2E, s0);
        wait_idle(to);
        chk("post_timeout", 32'(to), 0);
        chk("post_word", 32'(cap[0]), 32'h6B1D2E);
        chk("post_le_len", le_cnt[0], 10);
        chk("post_busy_len", busy_cnt, 510);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
